// File: rtl/regfile_pkg.sv
// Shared defaults for the register file family: widths, register count helper
// and the reset image used by the default core.
package regfile_pkg;

    localparam int unsigned DEF_DATA_W = 8;
    localparam int unsigned DEF_ADDR_W = 3;

    function automatic int unsigned num_regs(input int unsigned addr_w);
        return 32'd1 << addr_w;
    endfunction

    // Packed R7..R0, register i at [i*8 +: 8]: R1=1, R2=2, R5=5, others 0.
    localparam logic [DEF_DATA_W*8-1:0] CORE_RESET_IMAGE = {
        8'd0, 8'd0, 8'd5, 8'd0, 8'd0, 8'd2, 8'd1, 8'd0
    };

endpackage

// File: rtl/rf_scoreboard.sv
// In-flight write tracker: one pending bit per register, hazard stall and a
// registered count of outstanding writes.
module rf_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned ADDR_W   = DEF_ADDR_W,
    parameter bit          ZERO_REG = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              regWrite,
    input  logic [ADDR_W-1:0] rd,
    input  logic [ADDR_W-1:0] rs,
    input  logic [ADDR_W-1:0] rt,
    input  logic              issueValid,
    input  logic              issueWrites,
    input  logic [ADDR_W-1:0] issueRd,
    output logic              stall,
    output logic [ADDR_W:0]   pendingCount
);

    localparam int unsigned NUM_REGS = num_regs(ADDR_W);

    logic [NUM_REGS-1:0] r_pending;
    logic [ADDR_W:0]     r_count;
    logic [NUM_REGS-1:0] w_clr;
    logic [NUM_REGS-1:0] w_set;
    logic [NUM_REGS-1:0] w_busy;
    logic [NUM_REGS-1:0] w_next;
    logic                w_stall;
    logic                w_set_en;
    logic                w_inc;
    logic                w_dec;

    always_comb begin
        w_clr = '0;
        if (regWrite) begin
            w_clr[rd] = 1'b1;
        end

        // A register being written back this cycle is forwarded by the bypass.
        w_busy = r_pending & ~w_clr;
        if (ZERO_REG) begin
            w_busy[0] = 1'b0;
        end

        w_stall = !reset && issueValid &&
                  (w_busy[rs] || w_busy[rt] || (issueWrites && w_busy[issueRd]));

        w_set_en = issueValid && issueWrites && !w_stall &&
                   !(ZERO_REG && (issueRd == '0));
        w_set = '0;
        if (w_set_en) begin
            w_set[issueRd] = 1'b1;
        end

        w_next = (r_pending & ~w_clr) | w_set;

        // Same-register set+clear leaves the bit set and the count unchanged.
        w_inc = w_set_en && !r_pending[issueRd];
        w_dec = regWrite && r_pending[rd] && !(w_set_en && (issueRd == rd));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pending <= '0;
            r_count   <= '0;
        end else begin
            r_pending <= w_next;
            r_count   <= r_count + (ADDR_W+1)'(w_inc) - (ADDR_W+1)'(w_dec);
        end
    end

    assign stall        = w_stall;
    assign pendingCount = r_count;

endmodule

// File: rtl/reg_file_scoreboard.sv
// Register file with one write port, two bypassed read ports, per-register
// reset image, optional hardwired-zero R0 and an in-flight write scoreboard.
module reg_file_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned                        DATA_W     = DEF_DATA_W,
    parameter int unsigned                        ADDR_W     = DEF_ADDR_W,
    parameter logic [(2**ADDR_W)*DATA_W-1:0]      RESET_VALS = '0,
    parameter bit                                 ZERO_REG   = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              regWrite,
    input  logic [ADDR_W-1:0] rd,
    input  logic [DATA_W-1:0] writeData,
    input  logic [ADDR_W-1:0] rs,
    input  logic [ADDR_W-1:0] rt,
    output logic [DATA_W-1:0] regrs,
    output logic [DATA_W-1:0] regrt,
    input  logic              issueValid,
    input  logic              issueWrites,
    input  logic [ADDR_W-1:0] issueRd,
    output logic              stall,
    output logic [ADDR_W:0]   pendingCount
);

    localparam int unsigned NUM_REGS = num_regs(ADDR_W);

    logic [DATA_W-1:0] r_regs [NUM_REGS];
    logic              w_wr_en;
    logic              w_rs_zero;
    logic              w_rt_zero;

    assign w_wr_en   = regWrite && !(ZERO_REG && (rd == '0));
    assign w_rs_zero = ZERO_REG && (rs == '0);
    assign w_rt_zero = ZERO_REG && (rt == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= RESET_VALS[i*DATA_W +: DATA_W];
            end
        end else if (w_wr_en) begin
            r_regs[rd] <= writeData;
        end
    end

    // Hardwired zero takes priority over the bypass so R0 never forwards.
    assign regrs = w_rs_zero ? '0 :
                   (regWrite && (rd == rs)) ? writeData : r_regs[rs];
    assign regrt = w_rt_zero ? '0 :
                   (regWrite && (rd == rt)) ? writeData : r_regs[rt];

    rf_scoreboard #(
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk          (clk),
        .reset        (reset),
        .regWrite     (regWrite),
        .rd           (rd),
        .rs           (rs),
        .rt           (rt),
        .issueValid   (issueValid),
        .issueWrites  (issueWrites),
        .issueRd      (issueRd),
        .stall        (stall),
        .pendingCount (pendingCount)
    );

endmodule
